// File: rtl/swin_pkg.sv
// Shared types and limits for the switch input conditioner: FSM state
// encoding, default bus width and the legal ranges of the tuning parameters.
package swin_pkg;

    // Debounce FSM states: a stable level plus a "qualifying a change" state
    // for each level.
    typedef enum logic [1:0] {
        S_LOW,
        S_LOW_PEND,
        S_HIGH,
        S_HIGH_PEND
    } swin_state_e;

    localparam int DW_DEFAULT       = 8;

    localparam int SYNC_STAGES_MIN  = 2;
    localparam int SYNC_STAGES_MAX  = 4;
    localparam int DEBOUNCE_MIN     = 1;
    localparam int DEBOUNCE_MAX     = 65535;

    // Pins an elaboration-time parameter into its legal range so an illegal
    // override cannot build a zero-depth synchroniser or a zero-width counter.
    function automatic int clamp_range(input int value, input int lo, input int hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/sw_input_conditioner_sync_chain.sv
// sync_chain: WIDTH-bit, DEPTH-stage flip-flop synchroniser bringing
// asynchronous switch levels into the clk domain. Used for both the data bus
// and the handshake strobe.
module sync_chain
    import swin_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = SYNC_STAGES_MIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift the raw input through DEPTH flops; the last stage is the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this is a short shift register, not a RAM, so every stage
            // is cleared; a stale '1' here would fake a switch press after reset.
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, which is what makes this a shift chain.
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner: front end between the board switches and the
// picoMIPS core. Synchronises the data switches and the handshake switch,
// debounces the handshake into a clean level plus rise/fall pulses, and
// latches the data switches on every accepted press.
//
// Build option: define SWIN_DATA_DEBOUNCE_EN to add a per-bit stability
// filter on the data switches; data_out then captures the filtered value.
module sw_input_conditioner
    import swin_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 3
) (
    input  logic          fastclk,
    input  logic          nreset,
    input  logic [DW-1:0] sw_in,
    input  logic          strobe_in,
    output logic [DW-1:0] data_out,
    output logic          strobe_level,
    output logic          strobe_rise,
    output logic          strobe_fall,
    output logic          pending
);

    localparam int SYNC_N = clamp_range(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    localparam int DB_N   = clamp_range(DEBOUNCE, DEBOUNCE_MIN, DEBOUNCE_MAX);
    localparam int CW     = $clog2(DB_N + 1);

    localparam logic [CW-1:0] DB_LIMIT = CW'(DB_N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          s_sync;
    logic [DW-1:0] d_sync;
    logic [DW-1:0] capture_src;

    swin_state_e   state_q;
    swin_state_e   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rise_d;
    logic          fall_d;

    sync_chain #(
        .WIDTH (1),
        .DEPTH (SYNC_N)
    ) u_sync_strobe (
        .clk   (fastclk),
        .rst_n (nreset),
        .d     (strobe_in),
        .q     (s_sync)
    );

    sync_chain #(
        .WIDTH (DW),
        .DEPTH (SYNC_N)
    ) u_sync_data (
        .clk   (fastclk),
        .rst_n (nreset),
        .d     (sw_in),
        .q     (d_sync)
    );

`ifdef SWIN_DATA_DEBOUNCE_EN
    logic [DW-1:0] d_last;
    logic [DW-1:0] d_filt;

    // Remember last cycle's synchronised data so each bit can detect changes.
    always_ff @(posedge fastclk or negedge nreset) begin
        if (!nreset) begin
            d_last <= '0;
        end else begin
            d_last <= d_sync;
        end
    end

    for (genvar b = 0; b < DW; b++) begin : g_filt
        logic [CW-1:0] stab_cnt;
        logic          filt_bit;

        // Count how long this bit has held still; adopt it once it has been
        // unchanged for DB_N cycles, otherwise keep the last settled value.
        always_ff @(posedge fastclk or negedge nreset) begin
            if (!nreset) begin
                stab_cnt <= '0;
                filt_bit <= 1'b0;
            end else if (d_sync[b] != d_last[b]) begin
                stab_cnt <= '0;
            end else begin
                if (stab_cnt != DB_LIMIT) begin
                    stab_cnt <= stab_cnt + CNT_ONE;
                end
                if (stab_cnt == DB_LIMIT - CNT_ONE) begin
                    filt_bit <= d_sync[b];
                end
            end
        end

        assign d_filt[b] = filt_bit;
    end

    assign capture_src = d_filt;
`else
    assign capture_src = d_sync;
`endif

    // Next-state logic: a level change must persist for DB_N further cycles
    // in the PEND state before it is accepted; any reversion drops it.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            S_LOW: begin
                if (s_sync) begin
                    state_d = S_LOW_PEND;
                    cnt_d   = CNT_ONE;
                end
            end

            S_LOW_PEND: begin
                if (!s_sync) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LIMIT) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            S_HIGH: begin
                if (!s_sync) begin
                    state_d = S_HIGH_PEND;
                    cnt_d   = CNT_ONE;
                end
            end

            S_HIGH_PEND: begin
                if (s_sync) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LIMIT) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset discards any change still being qualified.
    always_ff @(posedge fastclk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs: level and edge pulses change on the accepting edge,
    // and the operand is latched only on an accepted press.
    always_ff @(posedge fastclk or negedge nreset) begin
        if (!nreset) begin
            strobe_level <= 1'b0;
            strobe_rise  <= 1'b0;
            strobe_fall  <= 1'b0;
            data_out     <= '0;
        end else begin
            strobe_level <= (state_d == S_HIGH) || (state_d == S_HIGH_PEND);
            strobe_rise  <= rise_d;
            strobe_fall  <= fall_d;
            if (rise_d) begin
                data_out <= capture_src;
            end
        end
    end

    assign pending = (state_q == S_LOW_PEND) || (state_q == S_HIGH_PEND);

endmodule
